shift_add_mul_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency shift_add_multiply datapath among N_REQ requesters. It accepts one request at a time, latches the operands, and pulses start to the multiplier. It waits the multiplier's fixed latency, captures the product and returns it with the requester ID under a valid/ready handshake. It sits between client blocks and the single multiplier instance.

---
 rtl/shift_add_mul_pkg.sv | 15 +
 rtl/shift_add_mul_sched_rr_arbiter.sv | 33 +++
 rtl/shift_add_mul_sched.sv | 115 +++++++++++
 tb/tb_shift_add_mul_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_pkg.sv
// Shared types and default sizes for the shift-add multiplier scheduler.
package shift_add_mul_pkg;

   localparam int unsigned DEF_WIDTH       = 32;
   localparam int unsigned DEF_N_REQ       = 4;
   localparam int unsigned DEF_MUL_LATENCY = 33;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/shift_add_mul_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] pick_c,
   output logic [ID_W-1:0]  pick_id_c,
   output logic             any_c
);

   logic        found;
   int unsigned idx;

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      pick_c    = '0;
      pick_id_c = '0;
      any_c     = |req;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr) + k) % N_REQ;
         if (!found && req[ID_W'(idx)]) begin
            found                = 1'b1;
            pick_c[ID_W'(idx)]   = 1'b1;
            pick_id_c            = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/shift_add_mul_sched.sv
// Round-robin scheduler sharing one fixed-latency multiplier among N_REQ clients.
module shift_add_mul_sched
   import shift_add_mul_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned N_REQ       = DEF_N_REQ,
   parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY,
   parameter int unsigned ID_W        = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       gnt,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic [2*WIDTH-1:0]     resp_product,
   output logic                   busy,
   output logic                   mul_start,
   output logic [WIDTH-1:0]       mul_multiplier,
   output logic [WIDTH-1:0]       mul_multiplicand,
   input  logic [2*WIDTH-1:0]     mul_product
);

   localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [ID_W-1:0]    ptr;
   logic [N_REQ-1:0]   pick_c;
   logic [ID_W-1:0]    pick_id_c;
   logic               any_c;
   logic [WIDTH-1:0]   pick_a_c;
   logic [WIDTH-1:0]   pick_b_c;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req       (req),
      .ptr       (ptr),
      .pick_c    (pick_c),
      .pick_id_c (pick_id_c),
      .any_c     (any_c)
   );

   // Operand mux for the winning requester.
   always_comb begin
      pick_a_c = '0;
      pick_b_c = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (pick_c[k]) begin
            pick_a_c = req_a[k*WIDTH +: WIDTH];
            pick_b_c = req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   // Scheduler FSM with latency counter, operand latch and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         ptr              <= '0;
         gnt              <= '0;
         mul_start        <= 1'b0;
         resp_valid       <= 1'b0;
         busy             <= 1'b0;
         resp_id          <= '0;
         resp_product     <= '0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
      end else begin
         gnt       <= '0;
         mul_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_c) begin
                  mul_multiplier   <= pick_a_c;
                  mul_multiplicand <= pick_b_c;
                  resp_id          <= pick_id_c;
                  gnt              <= pick_c;
                  mul_start        <= 1'b1;
                  busy             <= 1'b1;
                  state            <= ST_START;
               end
            end
            ST_START: begin
               cnt   <= CNT_W'(MUL_LATENCY);
               state <= ST_BUSY;
            end
            ST_BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  resp_product <= mul_product;
                  resp_valid   <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  ptr        <= (resp_id == ID_W'(N_REQ - 1)) ? '0 : resp_id + ID_W'(1);
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mul_sched.sv
// Scoreboard bench for shift_add_mul_sched with a fixed-latency multiplier model.
module tb_shift_add_mul_sched;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned N_REQ = 4;
   localparam int unsigned LAT   = 33;
   localparam int unsigned ID_W  = 2;
   localparam logic [63:0] JUNK  = 64'hBAD0_BAD1_BAD2_BAD3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       gnt;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [ID_W-1:0]        resp_id;
   logic [2*WIDTH-1:0]     resp_product;
   logic                   busy;
   logic                   mul_start;
   logic [WIDTH-1:0]       mul_multiplier;
   logic [WIDTH-1:0]       mul_multiplicand;
   logic [2*WIDTH-1:0]     mul_product;

   shift_add_mul_sched #(
      .WIDTH       (WIDTH),
      .N_REQ       (N_REQ),
      .MUL_LATENCY (LAT),
      .ID_W        (ID_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req              (req),
      .req_a            (req_a),
      .req_b            (req_b),
      .gnt              (gnt),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_id          (resp_id),
      .resp_product     (resp_product),
      .busy             (busy),
      .mul_start        (mul_start),
      .mul_multiplier   (mul_multiplier),
      .mul_multiplicand (mul_multiplicand),
      .mul_product      (mul_product)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
   } gexp_t;

   typedef struct {
      int          id;
      logic [63:0] p;
   } rexp_t;

   gexp_t gnt_q[$];
   rexp_t rsp_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int gnt_count = 0;
   int last_gnt_cyc = -1;
   bit spacing_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Multiplier model: product valid only in the cycle the scheduler should capture it.
   logic [5:0]  m_cnt;
   logic [31:0] m_a, m_b;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt       <= '0;
         m_a         <= '0;
         m_b         <= '0;
         mul_product <= JUNK;
      end else if (mul_start) begin
         m_cnt       <= 6'(LAT - 1);
         m_a         <= mul_multiplier;
         m_b         <= mul_multiplicand;
         mul_product <= JUNK;
      end else if (m_cnt > 6'd1) begin
         m_cnt       <= m_cnt - 6'd1;
         mul_product <= JUNK;
      end else if (m_cnt == 6'd1) begin
         m_cnt       <= '0;
         mul_product <= {32'd0, m_a} * {32'd0, m_b};
      end else begin
         mul_product <= JUNK;
      end
   end

   // Grant monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mul_start && gnt == '0) check("mul_start_without_gnt", 64'(mul_start), 64'd0);
         if (gnt != '0) begin
            if (gnt_q.size() == 0) begin
               check("unexpected_gnt", 64'(gnt), 64'd0);
            end else begin
               gexp_t g;
               g = gnt_q.pop_front();
               check("gnt_onehot", 64'(gnt), 64'(1) << g.id);
               check("gnt_mul_start", 64'(mul_start), 64'd1);
               check("gnt_multiplier", 64'(mul_multiplier), 64'(g.a));
               check("gnt_multiplicand", 64'(mul_multiplicand), 64'(g.b));
               if (spacing_en && last_gnt_cyc >= 0)
                  check("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'(LAT + 3));
            end
            last_gnt_cyc = cyc;
            gnt_count++;
         end
      end
   end

   // Response monitor: latency, stability under backpressure, scoreboard compare.
   bit          prev_valid = 1'b0;
   bit          prev_hs = 1'b0;
   logic [1:0]  held_id;
   logic [63:0] held_p;
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (!prev_valid) begin
            check("resp_latency", 64'(cyc - last_gnt_cyc), 64'(LAT + 1));
         end else if (!prev_hs) begin
            check("hold_resp_id", 64'(resp_id), 64'(held_id));
            check("hold_resp_product", resp_product, held_p);
         end
         held_id = resp_id;
         held_p  = resp_product;
         if (resp_ready) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
               rexp_t r;
               r = rsp_q.pop_front();
               check("resp_id", 64'(resp_id), 64'(r.id));
               check("resp_product", resp_product, r.p);
            end
         end
      end
      prev_valid = rst_n && resp_valid;
      prev_hs    = rst_n && resp_valid && resp_ready;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic expect_op(input int id, input logic [31:0] a, input logic [31:0] b, input bit has_rsp);
      gexp_t g;
      rexp_t r;
      g.id = id; g.a = a; g.b = b;
      gnt_q.push_back(g);
      if (has_rsp) begin
         r.id = id;
         r.p  = {32'd0, a} * {32'd0, b};
         rsp_q.push_back(r);
      end
   endtask

   task automatic wait_grants(input int target, input int budget);
      int n;
      n = 0;
      while (gnt_count < target && n < budget) begin
         tick(1);
         n++;
      end
      if (gnt_count < target) check("timeout_wait_gnt", 64'(gnt_count), 64'(target));
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || resp_valid) && n < budget) begin
         tick(1);
         n++;
      end
      if (busy || resp_valid) check("timeout_wait_idle", 64'(busy), 64'd0);
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!resp_valid && n < budget) begin
         tick(1);
         n++;
      end
      if (!resp_valid) check("timeout_wait_valid", 64'(resp_valid), 64'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      req        = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      #12;
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mul_start", 64'(mul_start), 64'd0);
      check("rst_multiplier", 64'(mul_multiplier), 64'd0);
      check("rst_resp_product", resp_product, 64'd0);
      check("rst_resp_id", 64'(resp_id), 64'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // Contention: all requesters held, order 0,1,2,3,0 with fixed spacing.
      for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 2), 32'd3);
      expect_op(0, 32'd2, 32'd3, 1'b1);
      expect_op(1, 32'd3, 32'd3, 1'b1);
      expect_op(2, 32'd4, 32'd3, 1'b1);
      expect_op(3, 32'd5, 32'd3, 1'b1);
      expect_op(0, 32'd2, 32'd3, 1'b1);
      spacing_en = 1'b1;
      req = 4'b1111;
      wait_grants(5, 400);
      req = '0;
      wait_idle(100);
      spacing_en = 1'b0;

      // Single request with 10 cycles of backpressure in DONE.
      set_ops(0, 32'd5, 32'd5);
      expect_op(0, 32'd5, 32'd5, 1'b1);
      resp_ready = 1'b0;
      req = 4'b0001;
      wait_grants(6, 20);
      req = '0;
      wait_valid(100);
      tick(10);
      check("bp_valid_held", 64'(resp_valid), 64'd1);
      check("bp_busy_held", 64'(busy), 64'd1);
      resp_ready = 1'b1;
      tick(1);
      check("bp_release_valid", 64'(resp_valid), 64'd0);
      check("bp_release_busy", 64'(busy), 64'd0);
      tick(2);
      check("idle_hold_multiplier", 64'(mul_multiplier), 64'd5);
      check("idle_hold_multiplicand", 64'(mul_multiplicand), 64'd5);

      // Wide operands.
      set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expect_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check("wide_model", {32'd0, 32'hFFFF_FFFF} * {32'd0, 32'hFFFF_FFFF}, 64'hFFFF_FFFE_0000_0001);
      req = 4'b0010;
      wait_grants(7, 20);
      req = '0;
      wait_idle(100);

      // Withdrawn request: req[1] pulses during BUSY and must not be served.
      set_ops(0, 32'd7, 32'd9);
      set_ops(3, 32'd11, 32'd13);
      expect_op(0, 32'd7, 32'd9, 1'b1);
      expect_op(3, 32'd11, 32'd13, 1'b1);
      req = 4'b0001;
      wait_grants(8, 20);
      req = '0;
      tick(5);
      req = 4'b0010;
      tick(1);
      req = 4'b1000;
      wait_grants(9, 100);
      req = '0;
      wait_idle(100);

      // Reset in the middle of BUSY discards the operation.
      set_ops(0, 32'd3, 32'd4);
      expect_op(0, 32'd3, 32'd4, 1'b0);
      req = 4'b0001;
      wait_grants(10, 20);
      req = '0;
      tick(23);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_resp_valid", 64'(resp_valid), 64'd0);
      check("midrst_multiplier", 64'(mul_multiplier), 64'd0);
      check("midrst_multiplicand", 64'(mul_multiplicand), 64'd0);
      check("midrst_resp_product", resp_product, 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      set_ops(2, 32'd6, 32'd7);
      expect_op(2, 32'd6, 32'd7, 1'b1);
      req = 4'b0100;
      wait_grants(11, 20);
      req = '0;
      wait_idle(100);
      tick(5);

      check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
      check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
